// File: rtl/cpu_ram_arbiter.sv
// cpu_ram_arbiter: shares one single-ported RAM between instruction fetch and data ports.
// Define ARB_IFETCH_BUF_EN to add a one-entry fetch buffer that serves repeated fetches without RAM.
module cpu_ram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  iren,
    input  logic [ADDR_W-1:0]     iaddr,
    output logic [DATA_W-1:0]     iload,
    output logic                  iwait,
    input  logic                  dren,
    input  logic [DATA_W/8-1:0]   dwen,
    input  logic [ADDR_W-1:0]     daddr,
    input  logic [DATA_W-1:0]     dstore,
    output logic [DATA_W-1:0]     dload,
    output logic                  dwait,
    output logic                  ram_req,
    output logic [DATA_W/8-1:0]   ram_wen,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    input  logic                  ram_ready,
    output logic                  err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SB = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {IDLE, DACC, IACC} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          d_req, i_req, i_hit, d_done, i_done;

    assign d_req  = dren | (|dwen);
    // A completion is only accepted if the owner still asks for exactly what was latched
    assign d_done = state == DACC && ram_ready && d_req && daddr == ram_addr && dwen == ram_wen;
    assign i_done = state == IACC && ram_ready && iren && iaddr == ram_addr;
    assign i_req  = iren & ~i_hit;
    assign iwait  = iren & ~i_done & ~i_hit;
    assign dwait  = d_req & ~d_done;
    assign dload  = d_done ? ram_rdata : '0;

`ifdef ARB_IFETCH_BUF_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    assign i_hit = iren && buf_valid && iaddr == buf_addr;
    assign iload = i_done ? ram_rdata : i_hit ? buf_data : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else if (i_done) begin
            buf_valid <= 1'b1;
            buf_addr  <= ram_addr;
            buf_data  <= ram_rdata;
        end else if (d_done && |ram_wen && ram_addr[ADDR_W-1:SB] == buf_addr[ADDR_W-1:SB]) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign i_hit = 1'b0;
    assign iload = i_done ? ram_rdata : '0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            ram_req   <= 1'b0;
            ram_wen   <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            err       <= 1'b0;
            cnt       <= '0;
        end else if (state == IDLE) begin
            if (d_req | i_req) begin
                state     <= d_req ? DACC : IACC;
                ram_req   <= 1'b1;
                ram_wen   <= d_req ? dwen : '0;
                ram_addr  <= d_req ? daddr : iaddr;
                ram_wdata <= d_req ? dstore : '0;
                cnt       <= '0;
            end
        end else if (ram_ready) begin
            state   <= IDLE;
            ram_req <= 1'b0;
        end else begin
            // Saturating wait counter; err latches once TIMEOUT non-ready cycles have elapsed
            if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
            if (cnt >= CW'(TIMEOUT - 1)) err <= 1'b1;
        end
    end
endmodule
